// File: rtl/roi_line_binarizer_pkg.sv
// Shared definitions for the ROI binarizer and the downstream segment recogniser:
// pixel polarity, default ROI geometry and the capture state encoding.
package roi_line_binarizer_pkg;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    localparam int WE_DEFAULT      = 180;
    localparam int HE_DEFAULT      = 240;
    localparam int H_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

endpackage

// File: rtl/roi_line_binarizer_video_timing_counter.sv
// Frame/line timing: vs/de edge detection and saturating pixel (x) and line (y) counters.
module video_timing_counter
    import roi_line_binarizer_pkg::*;
#(
    parameter int CNT_WIDTH = 11
) (
    input  logic                 video_clk,
    input  logic                 rst,
    input  logic                 vin_vs,
    input  logic                 vin_de,
    output logic                 vs_rise,
    output logic                 de_fall,
    output logic [CNT_WIDTH-1:0] x_cnt,
    output logic [CNT_WIDTH-1:0] y_cnt
);

    logic                 vs_q;
    logic                 de_q;
    logic [CNT_WIDTH-1:0] x_cnt_q;
    logic [CNT_WIDTH-1:0] x_cnt_d;
    logic [CNT_WIDTH-1:0] y_cnt_q;
    logic [CNT_WIDTH-1:0] y_cnt_d;

    assign vs_rise = vin_vs & ~vs_q;
    assign de_fall = ~vin_de & de_q;
    assign x_cnt   = x_cnt_q;
    assign y_cnt   = y_cnt_q;

    // Next-count logic; a new frame clears y even if a line ends in the same cycle.
    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (vin_de) begin
            if (x_cnt_q != {CNT_WIDTH{1'b1}}) begin
                x_cnt_d = x_cnt_q + CNT_WIDTH'(1);
            end else begin
                x_cnt_d = x_cnt_q;
            end
        end else if (de_fall) begin
            x_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            x_cnt_d = x_cnt_q;
        end
        if (vs_rise) begin
            y_cnt_d = {CNT_WIDTH{1'b0}};
        end else if (de_fall && (y_cnt_q != {CNT_WIDTH{1'b1}})) begin
            y_cnt_d = y_cnt_q + CNT_WIDTH'(1);
        end else begin
            y_cnt_d = y_cnt_q;
        end
    end

    // Timing registers.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            x_cnt_q <= {CNT_WIDTH{1'b0}};
            y_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            vs_q    <= vin_vs;
            de_q    <= vin_de;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
        end
    end

endmodule

// File: rtl/roi_line_binarizer.sv
// Crops a WE x HE region from the grey pixel stream, thresholds it to 1 bpp and
// publishes the two most recent ROI rows with a row index and a one-cycle strobe.
module roi_line_binarizer
    import roi_line_binarizer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WE         = WE_DEFAULT,
    parameter int HE         = HE_DEFAULT,
    parameter int ROI_X0     = 230,
    parameter int ROI_Y0     = 120,
    parameter int H_WIDTH    = H_WIDTH_DEFAULT,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  video_clk,
    input  logic                  rst,
    input  logic                  vin_vs,
    input  logic                  vin_de,
    input  logic [DATA_WIDTH-1:0] vin_data,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  line_clk,
    output logic [WE-1:0]         line1,
    output logic [WE-1:0]         line2,
    output logic [H_WIDTH-1:0]    h,
    output logic                  frame_done,
    output logic                  short_line
);

    localparam int                   COL_W    = (WE > 1) ? $clog2(WE) : 1;
    localparam logic [CNT_WIDTH-1:0] X0       = CNT_WIDTH'(ROI_X0);
    localparam logic [CNT_WIDTH-1:0] Y0       = CNT_WIDTH'(ROI_Y0);
    localparam logic [CNT_WIDTH-1:0] Y_LAST   = CNT_WIDTH'(ROI_Y0 + HE - 1);
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(WE - 1);
    localparam logic [H_WIDTH-1:0]   H_LAST   = H_WIDTH'(HE - 1);

    logic                  vs_rise_s;
    logic                  de_fall_s;
    logic [CNT_WIDTH-1:0]  x_cnt_s;
    logic [CNT_WIDTH-1:0]  y_cnt_s;
    logic [CNT_WIDTH-1:0]  col_s;
    logic                  pix_s;
    logic                  in_rows_s;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] thr_q, thr_d;
    logic [WE-1:0]         shift_q, shift_d;
    logic [H_WIDTH-1:0]    row_q, row_d;
    logic [WE-1:0]         line1_q, line1_d;
    logic [WE-1:0]         line2_q, line2_d;
    logic [H_WIDTH-1:0]    h_q, h_d;
    logic                  line_clk_q, line_clk_d;
    logic                  frame_done_q, frame_done_d;
    logic                  short_line_q, short_line_d;

    video_timing_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timing (
        .video_clk (video_clk),
        .rst       (rst),
        .vin_vs    (vin_vs),
        .vin_de    (vin_de),
        .vs_rise   (vs_rise_s),
        .de_fall   (de_fall_s),
        .x_cnt     (x_cnt_s),
        .y_cnt     (y_cnt_s)
    );

    assign col_s     = x_cnt_s - X0;
    assign pix_s     = (vin_data >= thr_q) ? WHITE : BLACK;
    assign in_rows_s = (y_cnt_s >= Y0) && (y_cnt_s <= Y_LAST);

    // Capture FSM; the row index is latched at row start because y_cnt moves on
    // before a short row reaches its publish cycle.
    always_comb begin
        state_d      = state_q;
        thr_d        = thr_q;
        shift_d      = shift_q;
        row_d        = row_q;
        line1_d      = line1_q;
        line2_d      = line2_q;
        h_d          = h_q;
        short_line_d = short_line_q;
        line_clk_d   = 1'b0;
        frame_done_d = line_clk_q && (h_q == H_LAST);
        if (vs_rise_s) begin
            thr_d        = threshold;
            shift_d      = {WE{1'b0}};
            line1_d      = {WE{1'b0}};
            line2_d      = {WE{1'b0}};
            short_line_d = 1'b0;
            state_d      = S_WAIT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_WAIT: begin
                    if (vin_de && in_rows_s && (x_cnt_s == X0)) begin
                        shift_d[0] = pix_s;
                        row_d      = H_WIDTH'(y_cnt_s - Y0);
                        state_d    = S_CAPTURE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_CAPTURE: begin
                    if (vin_de) begin
                        shift_d[col_s[COL_W-1:0]] = pix_s;
                        if (col_s == COL_LAST) begin
                            state_d = S_PUBLISH;
                        end else begin
                            state_d = S_CAPTURE;
                        end
                    end else begin
                        short_line_d = 1'b1;
                        state_d      = S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    line2_d    = line1_q;
                    line1_d    = shift_q;
                    h_d        = row_q;
                    line_clk_d = 1'b1;
                    shift_d    = {WE{1'b0}};
                    if (row_q == H_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            thr_q        <= {DATA_WIDTH{1'b0}};
            shift_q      <= {WE{1'b0}};
            row_q        <= {H_WIDTH{1'b0}};
            line1_q      <= {WE{1'b0}};
            line2_q      <= {WE{1'b0}};
            h_q          <= {H_WIDTH{1'b0}};
            line_clk_q   <= 1'b0;
            frame_done_q <= 1'b0;
            short_line_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            shift_q      <= shift_d;
            row_q        <= row_d;
            line1_q      <= line1_d;
            line2_q      <= line2_d;
            h_q          <= h_d;
            line_clk_q   <= line_clk_d;
            frame_done_q <= frame_done_d;
            short_line_q <= short_line_d;
        end
    end

    assign line_clk   = line_clk_q;
    assign line1      = line1_q;
    assign line2      = line2_q;
    assign h          = h_q;
    assign frame_done = frame_done_q;
    assign short_line = short_line_q;

endmodule

// File: tb/tb_roi_line_binarizer.sv
// Directed bench for roi_line_binarizer on a reduced ROI geometry so whole frames stay short.
module tb_roi_line_binarizer;

    localparam int DW = 8;
    localparam int WE = 32;
    localparam int HE = 16;
    localparam int X0 = 6;
    localparam int Y0 = 4;
    localparam int HW = 8;
    localparam int CW = 11;
    localparam int FULL = X0 + WE;

    logic          video_clk = 1'b0;
    logic          rst;
    logic          vin_vs;
    logic          vin_de;
    logic [DW-1:0] vin_data;
    logic [DW-1:0] threshold;
    logic          line_clk;
    logic [WE-1:0] line1;
    logic [WE-1:0] line2;
    logic [HW-1:0] h;
    logic          frame_done;
    logic          short_line;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [WE-1:0] q_l1[$];
    logic [WE-1:0] q_l2[$];
    logic [HW-1:0] q_h[$];
    int            q_cyc[$];
    int            fd_cyc[$];

    typedef struct {
        logic [DW-1:0] thr;
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic [WE-1:0] exp;
    } vec_t;
    vec_t tbl[6];

    roi_line_binarizer #(
        .DATA_WIDTH (DW), .WE (WE), .HE (HE), .ROI_X0 (X0), .ROI_Y0 (Y0),
        .H_WIDTH (HW), .CNT_WIDTH (CW)
    ) dut (
        .video_clk  (video_clk),
        .rst        (rst),
        .vin_vs     (vin_vs),
        .vin_de     (vin_de),
        .vin_data   (vin_data),
        .threshold  (threshold),
        .line_clk   (line_clk),
        .line1      (line1),
        .line2      (line2),
        .h          (h),
        .frame_done (frame_done),
        .short_line (short_line)
    );

    always #5 video_clk = ~video_clk;

    // Record every strobe and frame_done, sampled just after the active edge.
    always @(posedge video_clk) begin
        #1;
        cyc = cyc + 1;
        if (line_clk === 1'b1) begin
            q_l1.push_back(line1);
            q_l2.push_back(line2);
            q_h.push_back(h);
            q_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_cyc.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_strobe(input string nm, input int idx, input logic [WE-1:0] e1,
                              input logic [WE-1:0] e2, input int eh);
        if (q_l1.size() > idx) begin
            chk({nm, "_line1"}, 64'(q_l1[idx]), 64'(e1));
            chk({nm, "_line2"}, 64'(q_l2[idx]), 64'(e2));
            chk({nm, "_h"}, 64'(q_h[idx]), 64'(eh));
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL %s: strobe %0d missing, got %0d strobes", nm, idx, q_l1.size());
        end
    endtask

    task automatic clear_q();
        q_l1.delete(); q_l2.delete(); q_h.delete(); q_cyc.delete(); fd_cyc.delete();
    endtask

    task automatic tick(input logic de, input logic [DW-1:0] d);
        @(negedge video_clk);
        vin_de   = de;
        vin_data = d;
    endtask

    task automatic send_line(input int n_de, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                             input int split);
        for (int i = 0; i < n_de; i++) tick(1'b1, ((i - X0) < split) ? lo : hi);
        for (int i = 0; i < 4; i++) tick(1'b0, 8'd0);
    endtask

    task automatic frame_start(input logic [DW-1:0] thr);
        threshold = thr;
        @(negedge video_clk);
        vin_vs = 1'b1;
        @(negedge video_clk);
        @(negedge video_clk);
        vin_vs = 1'b0;
        repeat (2) @(negedge video_clk);
        for (int r = 0; r < Y0; r++) send_line(2, 8'd0, 8'd0, WE);
    endtask

    initial begin
        logic [WE-1:0] e1;
        logic [WE-1:0] e2;
        rst = 1'b1; vin_vs = 1'b0; vin_de = 1'b0; vin_data = 8'd0; threshold = 8'd0;
        repeat (3) @(negedge video_clk);
        chk("rst_line_clk", 64'(line_clk), 64'd0);
        chk("rst_line1", 64'(line1), 64'd0);
        chk("rst_line2", 64'(line2), 64'd0);
        chk("rst_h", 64'(h), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_short_line", 64'(short_line), 64'd0);
        rst = 1'b0;

        // Single-row threshold vectors: columns 0..15 get lo, 16..31 get hi.
        tbl[0] = '{8'd128, 8'd200, 8'd50,  32'h0000FFFF};
        tbl[1] = '{8'd100, 8'd100, 8'd99,  32'h0000FFFF};
        tbl[2] = '{8'd100, 8'd99,  8'd100, 32'hFFFF0000};
        tbl[3] = '{8'd0,   8'd0,   8'd0,   32'hFFFFFFFF};
        tbl[4] = '{8'd255, 8'd254, 8'd255, 32'hFFFF0000};
        tbl[5] = '{8'd200, 8'd10,  8'd20,  32'h00000000};
        for (int v = 0; v < 6; v++) begin
            clear_q();
            frame_start(tbl[v].thr);
            send_line(FULL, tbl[v].lo, tbl[v].hi, WE / 2);
            chk($sformatf("tbl%0d_count", v), 64'(q_l1.size()), 64'd1);
            chk_strobe($sformatf("tbl%0d", v), 0, tbl[v].exp, 32'h0, 0);
        end

        // Full frame plus one trailing line that must be ignored.
        clear_q();
        frame_start(8'd128);
        for (int r = 0; r < HE + 1; r++) send_line(FULL, 8'd200, 8'd50, WE / 2);
        chk("full_count", 64'(q_l1.size()), 64'(HE));
        for (int i = 0; i < HE; i++)
            chk_strobe($sformatf("full%0d", i), i, 32'h0000FFFF,
                       (i == 0) ? 32'h0 : 32'h0000FFFF, i);
        chk("full_fd_count", 64'(fd_cyc.size()), 64'd1);
        if (fd_cyc.size() > 0 && q_cyc.size() >= HE) begin
            chk("full_fd_cycle", 64'(fd_cyc[0]), 64'(q_cyc[HE-1] + 1));
        end else begin
            n_vec++; n_err++;
            $display("FAIL full_fd_cycle: got %0d pulses expected 1", fd_cyc.size());
        end

        // Alternating white/black rows.
        clear_q();
        frame_start(8'd128);
        for (int r = 0; r < 6; r++)
            send_line(FULL, (r % 2 == 0) ? 8'd255 : 8'd0, (r % 2 == 0) ? 8'd255 : 8'd0, WE);
        e2 = 32'h0;
        for (int i = 0; i < 6; i++) begin
            e1 = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h0;
            chk_strobe($sformatf("alt%0d", i), i, e1, e2, i);
            if (i > 0 && q_l1.size() > i)
                chk($sformatf("alt%0d_xor", i), 64'(q_l1[i] ^ q_l2[i]), 64'(32'hFFFFFFFF));
            e2 = e1;
        end

        // Short row 5: de drops after ROI column 10.
        clear_q();
        frame_start(8'd128);
        for (int r = 0; r < 5; r++) send_line(FULL, 8'd200, 8'd200, WE);
        chk("short_before", 64'(short_line), 64'd0);
        send_line(X0 + 11, 8'd200, 8'd200, WE);
        chk_strobe("short", 5, 32'h000007FF, 32'hFFFFFFFF, 5);
        chk("short_set", 64'(short_line), 64'd1);
        send_line(FULL, 8'd200, 8'd200, WE);
        chk("short_sticky", 64'(short_line), 64'd1);

        // Reset in the middle of row 7 capture.
        for (int i = 0; i < X0 + 8; i++) tick(1'b1, 8'd200);
        @(negedge video_clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_line_clk", 64'(line_clk), 64'd0);
        chk("mid_rst_line1", 64'(line1), 64'd0);
        chk("mid_rst_line2", 64'(line2), 64'd0);
        chk("mid_rst_h", 64'(h), 64'd0);
        chk("mid_rst_frame_done", 64'(frame_done), 64'd0);
        chk("mid_rst_short_line", 64'(short_line), 64'd0);
        repeat (2) @(negedge video_clk);
        vin_de = 1'b0;
        rst = 1'b0;
        clear_q();
        for (int r = 0; r < 3; r++) send_line(FULL, 8'd200, 8'd200, WE);
        chk("post_rst_no_strobe", 64'(q_l1.size()), 64'd0);
        frame_start(8'd128);
        send_line(FULL, 8'd200, 8'd50, WE / 2);
        chk_strobe("post_rst", 0, 32'h0000FFFF, 32'h0, 0);

        // vs rises during row 9 capture: that row is dropped and a new frame begins.
        clear_q();
        frame_start(8'd128);
        for (int r = 0; r < 9; r++) send_line(FULL, 8'd200, 8'd50, WE / 2);
        for (int i = 0; i < X0 + 10; i++) tick(1'b1, 8'd200);
        @(negedge video_clk);
        vin_de = 1'b0;
        vin_vs = 1'b1;
        @(negedge video_clk);
        @(negedge video_clk);
        vin_vs = 1'b0;
        repeat (3) @(negedge video_clk);
        chk("abort_count", 64'(q_l1.size()), 64'd9);
        for (int r = 0; r < Y0; r++) send_line(2, 8'd0, 8'd0, WE);
        send_line(FULL, 8'd0, 8'd255, WE / 2);
        chk("abort_next_count", 64'(q_l1.size()), 64'd10);
        chk_strobe("abort_next", 9, 32'hFFFF0000, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
